// File: rtl/ext_mem_responder.sv
// ext_mem_responder: off-chip memory model that terminates a multi-channel master
// memory bus and answers each accepted request after a programmable latency.
// Ports:
//   clock, reset              rising-edge clock, asynchronous active-low reset
//   base_addr                 window base address (stable while any channel busy)
//   Mout_oe_ram/Mout_we_ram   per-channel read / write request
//   Mout_addr_ram             per-channel byte address
//   Mout_Wdata_ram            per-channel write data
//   Mout_data_ram_size        per-channel access width in bits (write mask)
//   init_we/init_addr/init_data  preload port (offset relative to base_addr)
//   M_Rdata_ram               per-channel read data, zero unless M_DataRdy
//   M_DataRdy                 per-channel one-cycle completion pulse
//   conflict_err              sticky flag: oe and we seen together on an idle channel
module ext_mem_responder #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SIZE_W      = 4,
  parameter int unsigned MEMSIZE     = 32,
  parameter int unsigned READ_DELAY  = 2,
  parameter int unsigned WRITE_DELAY = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [CHANNELS-1:0]          Mout_oe_ram,
  input  logic [CHANNELS-1:0]          Mout_we_ram,
  input  logic [CHANNELS*ADDR_W-1:0]   Mout_addr_ram,
  input  logic [CHANNELS*DATA_W-1:0]   Mout_Wdata_ram,
  input  logic [CHANNELS*SIZE_W-1:0]   Mout_data_ram_size,
  input  logic                         init_we,
  input  logic [ADDR_W-1:0]            init_addr,
  input  logic [DATA_W-1:0]            init_data,
  output logic [CHANNELS*DATA_W-1:0]   M_Rdata_ram,
  output logic [CHANNELS-1:0]          M_DataRdy,
  output logic                         conflict_err
);

  localparam int unsigned OFF_W     = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam int unsigned MAX_DELAY = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
  localparam int unsigned CNT_W     = $clog2(MAX_DELAY + 1);
  localparam int unsigned AW1       = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_WR_WAIT} state_t;

  state_t              state_q [CHANNELS];
  state_t              state_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q   [CHANNELS];
  logic [CNT_W-1:0]    cnt_d   [CHANNELS];
  logic [DATA_W-1:0]   hold_q  [CHANNELS];
  logic [DATA_W-1:0]   hold_d  [CHANNELS];
  logic [DATA_W-1:0]   rdata_q [CHANNELS];
  logic [DATA_W-1:0]   rdata_d [CHANNELS];
  logic [CHANNELS-1:0] rdy_q, rdy_d;
  logic                conflict_q, conflict_d;

  logic [AW1-1:0]      off_full [CHANNELS];
  logic [CHANNELS-1:0] in_win;
  logic [CHANNELS-1:0] wr_en;
  logic [DATA_W-1:0]   wr_data  [CHANNELS];

  logic [DATA_W-1:0]   mem [MEMSIZE];

  // Bit b is writable when the access width covers it.
  function automatic logic [DATA_W-1:0] wr_mask(input logic [SIZE_W-1:0] size);
    wr_mask = '0;
    for (int b = 0; b < int'(DATA_W); b++) begin
      if (int'(size) > b) wr_mask[b] = 1'b1;
    end
  endfunction

  // Per-channel next-state, response and memory-write decode.
  always_comb begin
    conflict_d = conflict_q;
    rdy_d      = '0;
    wr_en      = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      state_d[c]  = state_q[c];
      cnt_d[c]    = cnt_q[c];
      hold_d[c]   = hold_q[c];
      rdata_d[c]  = '0;
      // Borrow in bit ADDR_W means addr < base_addr.
      off_full[c] = {1'b0, Mout_addr_ram[c*ADDR_W +: ADDR_W]} - {1'b0, base_addr};
      in_win[c]   = !off_full[c][ADDR_W] && (off_full[c] < AW1'(MEMSIZE));
      // Merge against the pre-edge contents so same-edge reads see old data.
      wr_data[c]  = (Mout_Wdata_ram[c*DATA_W +: DATA_W] & wr_mask(Mout_data_ram_size[c*SIZE_W +: SIZE_W]))
                  | (mem[off_full[c][OFF_W-1:0]] & ~wr_mask(Mout_data_ram_size[c*SIZE_W +: SIZE_W]));
      unique case (state_q[c])
        S_IDLE: begin
          if (Mout_oe_ram[c] && Mout_we_ram[c]) begin
            conflict_d = 1'b1;
          end else if (Mout_oe_ram[c] && in_win[c]) begin
            hold_d[c]  = mem[off_full[c][OFF_W-1:0]];
            cnt_d[c]   = CNT_W'(1);
            state_d[c] = S_RD_WAIT;
            if (READ_DELAY == 1) begin
              rdy_d[c]   = 1'b1;
              rdata_d[c] = hold_d[c];
            end
          end else if (Mout_we_ram[c] && in_win[c]) begin
            wr_en[c]   = 1'b1;
            cnt_d[c]   = CNT_W'(1);
            state_d[c] = S_WR_WAIT;
            rdy_d[c]   = (WRITE_DELAY == 1);
          end
        end
        S_RD_WAIT: begin
          // cnt == delay means DataRdy is high this cycle; this edge closes it.
          if (cnt_q[c] == CNT_W'(READ_DELAY)) begin
            state_d[c] = S_IDLE;
            cnt_d[c]   = '0;
          end else begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
            if (cnt_d[c] == CNT_W'(READ_DELAY)) begin
              rdy_d[c]   = 1'b1;
              rdata_d[c] = hold_q[c];
            end
          end
        end
        S_WR_WAIT: begin
          if (cnt_q[c] == CNT_W'(WRITE_DELAY)) begin
            state_d[c] = S_IDLE;
            cnt_d[c]   = '0;
          end else begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
            if (cnt_d[c] == CNT_W'(WRITE_DELAY)) rdy_d[c] = 1'b1;
          end
        end
        default: state_d[c] = S_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        state_q[c] <= S_IDLE;
        cnt_q[c]   <= '0;
        hold_q[c]  <= '0;
        rdata_q[c] <= '0;
      end
      rdy_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      rdata_q    <= rdata_d;
      rdy_q      <= rdy_d;
      conflict_q <= conflict_d;
    end
  end

  // Backing store, not cleared by reset; later assignments win (channels beat preload).
  always_ff @(posedge clock) begin
    if (init_we && ({1'b0, init_addr} < AW1'(MEMSIZE))) begin
      mem[init_addr[OFF_W-1:0]] <= init_data;
    end
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (wr_en[c]) mem[off_full[c][OFF_W-1:0]] <= wr_data[c];
    end
  end

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_out
    assign M_Rdata_ram[g*DATA_W +: DATA_W] = rdata_q[g];
  end
  assign M_DataRdy    = rdy_q;
  assign conflict_err = conflict_q;

endmodule

// File: tb/tb_ext_mem_responder.sv
// Self-checking bench for ext_mem_responder: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-timing model of the memory.
module tb_ext_mem_responder;

  localparam int CH      = 2;
  localparam int MEMSIZE = 32;
  localparam int RD      = 2;
  localparam int WD      = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  base_addr;
  logic [1:0]  oe, we;
  logic [13:0] addr_bus;
  logic [15:0] wdata_bus;
  logic [7:0]  size_bus;
  logic        init_we;
  logic [6:0]  init_addr;
  logic [7:0]  init_data;
  logic [15:0] rdata_bus;
  logic [1:0]  rdy;
  logic        conf;

  int errors = 0;
  int checks = 0;

  // Model state: memory image plus, per channel, absolute edge numbers.
  logic [7:0] mm [MEMSIZE];
  int         ecount;
  int         resp_edge [CH];
  int         free_edge [CH];
  bit         resp_rd   [CH];
  logic [7:0] resp_data [CH];
  bit         exp_rdy   [CH];
  logic [7:0] exp_rdata [CH];
  bit         exp_conf;

  always #5 clock = ~clock;

  ext_mem_responder dut (
    .clock              (clock),
    .reset              (reset),
    .base_addr          (base_addr),
    .Mout_oe_ram        (oe),
    .Mout_we_ram        (we),
    .Mout_addr_ram      (addr_bus),
    .Mout_Wdata_ram     (wdata_bus),
    .Mout_data_ram_size (size_bus),
    .init_we            (init_we),
    .init_addr          (init_addr),
    .init_data          (init_data),
    .M_Rdata_ram        (rdata_bus),
    .M_DataRdy          (rdy),
    .conflict_err       (conf)
  );

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      resp_edge[c] = -1;
      free_edge[c] = 0;
      exp_rdy[c]   = 1'b0;
      exp_rdata[c] = 8'h00;
    end
    exp_conf = 1'b0;
  endtask

  // Effect of one rising edge, using the inputs present just before it.
  task automatic model_edge();
    logic [7:0] old [MEMSIZE];
    old = mm;
    for (int c = 0; c < CH; c++) begin
      exp_rdy[c]   = 1'b0;
      exp_rdata[c] = 8'h00;
    end
    if (init_we && int'(init_addr) < MEMSIZE) mm[int'(init_addr)] = init_data;
    if (!reset) begin
      model_reset();
    end else begin
      for (int c = 0; c < CH; c++) begin
        int a;
        int off;
        int sz;
        logic [7:0] m;
        logic [7:0] wd;
        a   = int'(addr_bus[c*7 +: 7]);
        off = a - int'(base_addr);
        if (ecount >= free_edge[c]) begin
          if (oe[c] && we[c]) begin
            exp_conf = 1'b1;
          end else if ((oe[c] || we[c]) && off >= 0 && off < MEMSIZE) begin
            if (oe[c]) begin
              resp_rd[c]   = 1'b1;
              resp_data[c] = old[off];
              resp_edge[c] = ecount + RD - 1;
              free_edge[c] = ecount + RD + 1;
            end else begin
              sz = int'(size_bus[c*4 +: 4]);
              m  = (sz >= 8) ? 8'hFF : 8'((1 << sz) - 1);
              wd = wdata_bus[c*8 +: 8];
              mm[off]      = (wd & m) | (old[off] & ~m);
              resp_rd[c]   = 1'b0;
              resp_edge[c] = ecount + WD - 1;
              free_edge[c] = ecount + WD + 1;
            end
          end
        end
        if (resp_edge[c] == ecount) begin
          exp_rdy[c]   = 1'b1;
          exp_rdata[c] = resp_rd[c] ? resp_data[c] : 8'h00;
        end
      end
    end
    ecount++;
  endtask

  task automatic compare_all();
    for (int c = 0; c < CH; c++) begin
      check($sformatf("DataRdy ch%0d t=%0t", c, $time), int'(rdy[c]), int'(exp_rdy[c]));
      check($sformatf("Rdata ch%0d t=%0t", c, $time), int'(rdata_bus[c*8 +: 8]), int'(exp_rdata[c]));
    end
    check($sformatf("conflict_err t=%0t", $time), int'(conf), int'(exp_conf));
  endtask

  // One clock: advance the model at the edge, then compare 2 time units later.
  task automatic step();
    @(posedge clock);
    model_edge();
    #2;
    compare_all();
  endtask

  task automatic drive(input int ch, input bit rd, input bit wr, input int a,
                       input logic [7:0] wd, input logic [3:0] sz);
    oe[ch] = rd;
    we[ch] = wr;
    addr_bus[ch*7 +: 7]  = 7'(a);
    wdata_bus[ch*8 +: 8] = wd;
    size_bus[ch*4 +: 4]  = sz;
  endtask

  task automatic preload(input int off, input logic [7:0] d);
    init_we = 1'b1; init_addr = 7'(off); init_data = d;
    step();
    init_we = 1'b0;
  endtask

  // Master-style request: hold until DataRdy, report edges waited and read data.
  task automatic do_req(input int ch, input bit wr, input int a, input logic [7:0] wd,
                        input logic [3:0] sz, output logic [7:0] rd, output int lat);
    lat = 0;
    rd  = 8'h00;
    drive(ch, !wr, wr, a, wd, sz);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (rdy[ch]) begin
        lat = k;
        rd  = rdata_bus[ch*8 +: 8];
        break;
      end
    end
    drive(ch, 1'b0, 1'b0, a, wd, sz);
    check($sformatf("response arrived ch%0d addr %0h", ch, a), int'(lat != 0), 1);
    step();
    step();
  endtask

  initial begin
    logic [7:0] d;
    int lat;
    reset = 1'b0; base_addr = 7'h10; oe = '0; we = '0;
    addr_bus = '0; wdata_bus = '0; size_bus = '0;
    init_we = 1'b0; init_addr = '0; init_data = '0;
    ecount = 0;
    model_reset();
    #1;
    check("reset DataRdy", int'(rdy), 0);
    check("reset Rdata", int'(rdata_bus), 0);
    check("reset conflict_err", int'(conf), 0);
    step(); step();
    reset = 1'b1;

    for (int i = 0; i < MEMSIZE; i++) preload(i, 8'($urandom));

    // Preloaded byte read through channel 0 with read latency 2.
    preload(3, 8'hA5);
    do_req(0, 1'b0, 'h13, 8'h00, 4'd0, d, lat);
    check("t1 read latency", lat, 2);
    check("t1 read data", int'(d), 'hA5);

    // Masked 4-bit write on channel 1, then read back.
    preload(2, 8'hF0);
    do_req(1, 1'b1, 'h12, 8'h3C, 4'd4, d, lat);
    check("t2 write latency", lat, 1);
    check("t2 model mem[2]", int'(mm[2]), 'hFC);
    do_req(0, 1'b0, 'h12, 8'h00, 4'd0, d, lat);
    check("t2 readback", int'(d), 'hFC);

    // Same-edge writes to one offset: highest channel wins.
    drive(0, 1'b0, 1'b1, 'h15, 8'h11, 4'd8);
    drive(1, 1'b0, 1'b1, 'h15, 8'h22, 4'd8);
    step();
    check("t3 both DataRdy", int'(rdy), 3);
    drive(0, 1'b0, 1'b0, 0, 8'h00, 4'd0);
    drive(1, 1'b0, 1'b0, 0, 8'h00, 4'd0);
    step(); step();
    check("t3 model mem[5]", int'(mm[5]), 'h22);
    do_req(1, 1'b0, 'h15, 8'h00, 4'd0, d, lat);
    check("t3 readback", int'(d), 'h22);

    // Out-of-window read never answers.
    drive(0, 1'b1, 1'b0, 'h30, 8'h00, 4'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("t4 no DataRdy cycle %0d", k), int'(rdy[0]), 0);
      check($sformatf("t4 Rdata zero cycle %0d", k), int'(rdata_bus[7:0]), 0);
    end
    drive(0, 1'b0, 1'b0, 0, 8'h00, 4'd0);
    step(); step();

    // Randomized traffic over three windows, including one clipped at the top.
    for (int ph = 0; ph < 3; ph++) begin
      base_addr = (ph == 0) ? 7'h10 : (ph == 1) ? 7'h60 : 7'h70;
      for (int cyc = 0; cyc < 400; cyc++) begin
        for (int c = 0; c < CH; c++) begin
          int r;
          int a;
          r = int'($urandom_range(0, 7));
          if ($urandom_range(0, 3) == 0) a = int'(base_addr) + int'($urandom_range(0, 3));
          else a = int'(base_addr) - 3 + int'($urandom_range(0, MEMSIZE + 5));
          drive(c, r < 3, (r >= 3) && (r < 5), a, 8'($urandom), 4'($urandom_range(0, 15)));
        end
        init_we   = ($urandom_range(0, 7) == 0);
        init_addr = 7'($urandom_range(0, 39));
        init_data = 8'($urandom);
        step();
      end
      oe = '0; we = '0; init_we = 1'b0;
      for (int k = 0; k < 4; k++) step();
    end

    // Reset while a read response is on the bus.
    base_addr = 7'h10;
    preload(3, 8'hA5);
    drive(0, 1'b1, 1'b0, 'h13, 8'h00, 4'd0);
    step();
    step();
    reset = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("t6 DataRdy cleared by reset", int'(rdy), 0);
    check("t6 Rdata cleared by reset", int'(rdata_bus), 0);
    drive(0, 1'b0, 1'b0, 0, 8'h00, 4'd0);
    step(); step();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("t6 no DataRdy after release %0d", k), int'(rdy), 0);
    end
    do_req(0, 1'b0, 'h13, 8'h00, 4'd0, d, lat);
    check("t6 mem intact", int'(d), 'hA5);

    // Simultaneous oe and we: sticky error, no access.
    preload(2, 8'h5A);
    drive(1, 1'b1, 1'b1, 'h12, 8'h00, 4'd8);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("t5 no DataRdy %0d", k), int'(rdy[1]), 0);
    end
    check("t5 conflict_err set", int'(conf), 1);
    drive(1, 1'b0, 1'b0, 0, 8'h00, 4'd0);
    step(); step(); step();
    check("t5 conflict_err sticky", int'(conf), 1);
    do_req(0, 1'b0, 'h12, 8'h00, 4'd0, d, lat);
    check("t5 mem unchanged", int'(d), 'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
